data_ram_responder: RTL and testbench

- Single-port synchronous data RAM that answers the load/store requests issued by the memory-access pipeline stage. It is the responder end of the stage's data-bus interface.
- Accepts one request at a time over a req/ack handshake. Inserts a configurable number of wait states. Returns read data or an error flag with a one-cycle acknowledge.
- Sits between the memory-access stage and on-chip data storage. It is used for simulation and for FPGA bring-up.

---
 rtl/data_ram_responder.sv | 137 +++++++++++++
 tb/tb_data_ram_responder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_ram_responder.sv
// Single-port word RAM answering load/store requests over a req/ack handshake,
// with a fixed number of wait states between acceptance and acknowledge.
module data_ram_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        busy_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t                r_state;
    logic [3:0]            r_count;
    logic                  r_we;
    logic [31:0]           r_addr;
    logic [3:0]            r_be;
    logic [31:0]           r_wdata;
    logic                  r_ack;
    logic                  r_err;
    logic [31:0]           r_rdata;
    logic [31:0]           r_mem [DEPTH];

    logic                  w_accept;
    logic                  w_enterResp;
    logic                  w_we;
    logic [31:0]           w_addr;
    logic [3:0]            w_be;
    logic [31:0]           w_wdata;
    logic                  w_misaligned;
    logic                  w_outOfRange;
    logic                  w_err;
    logic [ADDR_WIDTH-1:0] w_index;

    // With zero wait states the access completes on the accepting edge, so the
    // operation is taken straight from the inputs instead of the latched copy.
    assign w_accept     = (r_state == IDLE) && req_i;
    assign w_enterResp  = (w_accept && (WAIT_STATES == 0)) ||
                          ((r_state == WAIT) && (r_count == 4'd0));
    assign w_we         = (r_state == IDLE) ? we_i    : r_we;
    assign w_addr       = (r_state == IDLE) ? addr_i  : r_addr;
    assign w_be         = (r_state == IDLE) ? be_i    : r_be;
    assign w_wdata      = (r_state == IDLE) ? wdata_i : r_wdata;
    assign w_misaligned = |w_addr[1:0];
    assign w_outOfRange = |w_addr[31:ADDR_WIDTH+2];
    assign w_err        = w_misaligned || w_outOfRange;
    assign w_index      = w_addr[ADDR_WIDTH+1:2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_count <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_be    <= 4'd0;
            r_wdata <= 32'd0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= 32'd0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_i) begin
                        r_we    <= we_i;
                        r_addr  <= addr_i;
                        r_be    <= be_i;
                        r_wdata <= wdata_i;
                        if (WAIT_STATES == 0) begin
                            r_state <= RESP;
                        end else begin
                            r_state <= WAIT;
                            r_count <= 4'(WAIT_STATES - 1);
                        end
                    end
                end
                WAIT: begin
                    if (r_count == 4'd0) begin
                        r_state <= RESP;
                    end else begin
                        r_count <= r_count - 4'd1;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase

            // Response is registered on the same edge that enters RESP.
            if (w_enterResp) begin
                r_ack <= 1'b1;
                r_err <= w_err;
                if (w_err) begin
                    r_rdata <= 32'd0;
                end else if (!w_we) begin
                    r_rdata <= r_mem[w_index];
                end
            end
        end
    end

    // Storage is never reset; a reset on the writing edge still blocks the store.
    always_ff @(posedge clk) begin
        if (w_enterResp && w_we && !w_err && !rst) begin
            for (int lane = 0; lane < 4; lane++) begin
                if (w_be[lane]) begin
                    r_mem[w_index][8*lane +: 8] <= w_wdata[8*lane +: 8];
                end
            end
        end
    end

    assign ack_o   = r_ack;
    assign err_o   = r_err;
    assign rdata_o = r_rdata;
    assign busy_o  = (r_state != IDLE);

endmodule

// File: tb/tb_data_ram_responder.sv
// Scoreboard bench for data_ram_responder: three instances with 1, 3 and 0 wait
// states, checked every cycle against a bench-side RAM and timing model.
module tb_data_ram_responder;

    typedef struct {
        int          unit;
        int          ackCycle;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        reqI   [3];
    logic        weI    [3];
    logic [31:0] addrI  [3];
    logic [3:0]  beI    [3];
    logic [31:0] wdataI [3];
    logic        ackO   [3];
    logic [31:0] rdataO [3];
    logic        errO   [3];
    logic        busyO  [3];

    exp_t        expQ[$];
    logic [31:0] modelMem   [3][1024];
    logic [31:0] ackedRdata [3];
    int          lastAccept [3];
    int          readyCycle [3];
    int          cycleCount;
    int          checkCount;
    int          passCount;

    for (genvar g = 0; g < 3; g++) begin : gUnit
        data_ram_responder #(
            .ADDR_WIDTH (10),
            .WAIT_STATES(g == 0 ? 1 : (g == 1 ? 3 : 0))
        ) dut (
            .clk    (clk),
            .rst    (rst),
            .req_i  (reqI[g]),
            .we_i   (weI[g]),
            .addr_i (addrI[g]),
            .be_i   (beI[g]),
            .wdata_i(wdataI[g]),
            .ack_o  (ackO[g]),
            .rdata_o(rdataO[g]),
            .err_o  (errO[g]),
            .busy_o (busyO[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wsOf(input int u);
        return (u == 0) ? 1 : ((u == 1) ? 3 : 0);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)",
                     tag, actual, expected, cycleCount);
        end
    endtask

    // Drives one request once the model says the unit is idle; when track is set
    // the expected response and RAM effect are recorded at acceptance.
    task automatic applyStimulus(input int u, input logic we, input logic [31:0] addr,
                                 input logic [3:0] be, input logic [31:0] wdata,
                                 input bit track);
        exp_t       e;
        logic [9:0] idx;
        @(negedge clk);
        #1;
        while (cycleCount < readyCycle[u]) begin
            @(negedge clk);
            #1;
        end
        reqI[u]   = 1'b1;
        weI[u]    = we;
        addrI[u]  = addr;
        beI[u]    = be;
        wdataI[u] = wdata;
        if (track) begin
            idx        = addr[11:2];
            e.unit     = u;
            e.ackCycle = cycleCount + wsOf(u) + 1;
            e.err      = (addr[1:0] != 2'b00) || (addr[31:12] != 20'd0);
            if (e.err) begin
                e.rdata = 32'd0;
            end else if (!we) begin
                e.rdata = modelMem[u][idx];
            end else begin
                e.rdata = (expQ.size() > 0) ? expQ[$].rdata : ackedRdata[u];
                for (int lane = 0; lane < 4; lane++) begin
                    if (be[lane]) modelMem[u][idx][8*lane +: 8] = wdata[8*lane +: 8];
                end
            end
            expQ.push_back(e);
            lastAccept[u] = cycleCount;
            readyCycle[u] = cycleCount + wsOf(u) + 2;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (expQ.size() > 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        #1;
        checkOutput("drain", 32'(expQ.size()), 32'd0);
    endtask

    // Per-cycle scoreboard: ack/err/rdata against queued responses, busy against
    // the acceptance window, and rdata holding its last response otherwise.
    always @(negedge clk) begin
        exp_t e;
        cycleCount++;
        for (int u = 0; u < 3; u++) begin
            if (expQ.size() > 0 && expQ[0].unit == u && expQ[0].ackCycle == cycleCount) begin
                e = expQ.pop_front();
                checkOutput($sformatf("ack u%0d", u), 32'(ackO[u]), 32'd1);
                checkOutput($sformatf("err u%0d", u), 32'(errO[u]), 32'(e.err));
                checkOutput($sformatf("rdata u%0d", u), rdataO[u], e.rdata);
                ackedRdata[u] = e.rdata;
            end else begin
                checkOutput($sformatf("idle ack u%0d", u), 32'(ackO[u]), 32'd0);
                checkOutput($sformatf("idle err u%0d", u), 32'(errO[u]), 32'd0);
                checkOutput($sformatf("hold rdata u%0d", u), rdataO[u], ackedRdata[u]);
            end
            checkOutput($sformatf("busy u%0d", u), 32'(busyO[u]),
                        32'((cycleCount > lastAccept[u]) && (cycleCount < readyCycle[u])));
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        cycleCount = 0;
        checkCount = 0;
        passCount  = 0;
        for (int u = 0; u < 3; u++) begin
            reqI[u]       = 1'b0;
            weI[u]        = 1'b0;
            addrI[u]      = 32'd0;
            beI[u]        = 4'd0;
            wdataI[u]     = 32'd0;
            ackedRdata[u] = 32'd0;
            lastAccept[u] = -10;
            readyCycle[u] = 0;
        end
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;

        $display("[TB] unit0 (1 wait state): full, partial and error accesses");
        applyStimulus(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1);
        applyStimulus(0, 1'b1, 32'h0, 4'hF, 32'h01234567, 1);
        applyStimulus(0, 1'b0, 32'h10, 4'h0, 32'h0, 1);
        applyStimulus(0, 1'b1, 32'h10, 4'b0101, 32'h11223344, 1);
        applyStimulus(0, 1'b0, 32'h10, 4'hF, 32'h0, 1);
        applyStimulus(0, 1'b0, 32'h12, 4'hF, 32'h0, 1);
        applyStimulus(0, 1'b1, 32'h1000, 4'hF, 32'hBAADF00D, 1);
        applyStimulus(0, 1'b0, 32'h0, 4'hF, 32'h0, 1);
        applyStimulus(0, 1'b1, 32'h20, 4'hF, 32'hCAFEF00D, 1);
        applyStimulus(0, 1'b0, 32'h20, 4'hF, 32'h0, 1);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 1)) << 4,
                          4'($urandom), $urandom, 1);
        end
        applyStimulus(0, 1'b0, 32'h20, 4'hF, 32'h0, 1);
        reqI[0] = 1'b0;
        drain();

        $display("[TB] unit0: reset during WAIT aborts a store");
        applyStimulus(0, 1'b1, 32'h20, 4'hF, 32'h12345678, 0);
        reqI[0] = 1'b0;
        rst     = 1'b1;
        for (int u = 0; u < 3; u++) ackedRdata[u] = 32'd0;
        readyCycle[0] = cycleCount;
        #1;
        checkOutput("reset ack", 32'(ackO[0]), 32'd0);
        checkOutput("reset busy", 32'(busyO[0]), 32'd0);
        checkOutput("reset err", 32'(errO[0]), 32'd0);
        checkOutput("reset rdata", rdataO[0], 32'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        applyStimulus(0, 1'b0, 32'h20, 4'hF, 32'h0, 1);
        reqI[0] = 1'b0;
        drain();

        $display("[TB] unit2 (0 wait states): request held high back to back");
        applyStimulus(2, 1'b1, 32'h0, 4'hF, 32'hA0A0A0A0, 1);
        applyStimulus(2, 1'b1, 32'h4, 4'hF, 32'hB1B1B1B1, 1);
        applyStimulus(2, 1'b1, 32'h8, 4'hF, 32'hC2C2C2C2, 1);
        applyStimulus(2, 1'b0, 32'h0, 4'hF, 32'h0, 1);
        applyStimulus(2, 1'b0, 32'h4, 4'hF, 32'h0, 1);
        applyStimulus(2, 1'b0, 32'h8, 4'hF, 32'h0, 1);
        applyStimulus(2, 1'b1, 32'h4, 4'h0, 32'hFFFFFFFF, 1);
        applyStimulus(2, 1'b0, 32'h4, 4'hF, 32'h0, 1);
        reqI[2] = 1'b0;
        drain();

        $display("[TB] unit1 (3 wait states): inputs scrambled after acceptance");
        applyStimulus(1, 1'b1, 32'h44, 4'hF, 32'h5A5AA5A5, 1);
        reqI[1] = 1'b0; weI[1] = 1'b0; addrI[1] = 32'h3; beI[1] = 4'h0; wdataI[1] = $urandom;
        applyStimulus(1, 1'b0, 32'h44, 4'h0, 32'h0, 1);
        reqI[1] = 1'b0; weI[1] = 1'b1; addrI[1] = 32'h44; beI[1] = 4'hF; wdataI[1] = $urandom;
        applyStimulus(1, 1'b1, 32'hFFC, 4'hF, 32'h76543210, 1);
        reqI[1] = 1'b0; weI[1] = 1'b1; addrI[1] = 32'h2000; beI[1] = 4'hF; wdataI[1] = $urandom;
        applyStimulus(1, 1'b0, 32'hFFC, 4'hF, 32'h0, 1);
        reqI[1] = 1'b0;
        drain();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
